// File: rtl/carwash_pkg.sv
// Shared carwash constants: default timer parameters and the controller state encoding.
package carwash_pkg;

  localparam int PRESCALE_DEF = 1000;
  localparam int T1_TICKS_DEF = 30;
  localparam int T2_TICKS_DEF = 10;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } carwash_state_e;

endpackage

// File: rtl/carwash_interval_timer.sv
// Self-prescaled interval timer: sticky done flag raised PRESCALE*TICKS counting
// cycles after the level clear is released; saturates after expiry.
module carwash_interval_timer
  import carwash_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int TICKS    = T1_TICKS_DEF
) (
  input  logic clk,
  input  logic CLR,
  input  logic clr_i,
  input  logic freeze_i,
  output logic done_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 1);

  if (PRESCALE < 1 || TICKS < 1) begin : g_param_check
    $error("carwash_interval_timer: PRESCALE and TICKS must both be >= 1");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      pre_d  = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!freeze_i && !done_q) begin
      // Once done is set all count state holds, so the counter never wraps.
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          done_d = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/carwash_timers.sv
// Spray (T1) and rinse (T2) interval timers for the carwash controller; wiring only.
module carwash_timers
  import carwash_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int T1_TICKS = T1_TICKS_DEF,
  parameter int T2_TICKS = T2_TICKS_DEF
) (
  input  logic clk,
  input  logic CLR,
  input  logic CLRT1,
  input  logic CLRT2,
  input  logic FREEZE,
  output logic T1DONE,
  output logic T2DONE
);

  carwash_interval_timer #(
    .PRESCALE (PRESCALE),
    .TICKS    (T1_TICKS)
  ) u_t1_spray (
    .clk      (clk),
    .CLR      (CLR),
    .clr_i    (CLRT1),
    .freeze_i (FREEZE),
    .done_o   (T1DONE)
  );

  carwash_interval_timer #(
    .PRESCALE (PRESCALE),
    .TICKS    (T2_TICKS)
  ) u_t2_rinse (
    .clk      (clk),
    .CLR      (CLR),
    .clr_i    (CLRT2),
    .freeze_i (FREEZE),
    .done_o   (T2DONE)
  );

endmodule

// File: tb/tb_carwash_timers.sv
// Directed bench for carwash_timers with PRESCALE=4, T1_TICKS=3, T2_TICKS=2
// (T1 latency 12 cycles, T2 latency 8 cycles).
module tb_carwash_timers;

  logic clk;
  logic CLR;
  logic CLRT1;
  logic CLRT2;
  logic FREEZE;
  logic T1DONE;
  logic T2DONE;

  int n_checks = 0;
  int n_errors = 0;

  carwash_timers #(
    .PRESCALE (4),
    .T1_TICKS (3),
    .T2_TICKS (2)
  ) dut (
    .clk    (clk),
    .CLR    (CLR),
    .CLRT1  (CLRT1),
    .CLRT2  (CLRT2),
    .FREEZE (FREEZE),
    .T1DONE (T1DONE),
    .T2DONE (T2DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge: start of the next cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    CLR    = 1'b1;
    CLRT1  = 1'b0;
    CLRT2  = 1'b0;
    FREEZE = 1'b0;

    // 1: reset, then both clears held high
    next_cycle();
    next_cycle();
    chk("reset T1DONE", T1DONE, 1'b0);
    chk("reset T2DONE", T2DONE, 1'b0);
    CLR   = 1'b0;
    CLRT1 = 1'b1;
    CLRT2 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      chk($sformatf("t1 held T1DONE c=%0d", c), T1DONE, 1'b0);
      chk($sformatf("t1 held T2DONE c=%0d", c), T2DONE, 1'b0);
    end

    // 2: T1 released at cycle 0, expires at 12 and stays set for 50 cycles
    CLRT1 = 1'b0;
    for (int c = 0; c < 62; c++) begin
      chk($sformatf("t2 T1DONE c=%0d", c), T1DONE, (c >= 12) ? 1'b1 : 1'b0);
      chk($sformatf("t2 T2DONE c=%0d", c), T2DONE, 1'b0);
      next_cycle();
    end

    // 3: T2 released at cycle 0, FREEZE over cycles 3..7 delays expiry to 13;
    //    T1 clear held high alongside FREEZE
    CLRT1 = 1'b1;
    CLRT2 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      FREEZE = (c >= 3 && c <= 7) ? 1'b1 : 1'b0;
      chk($sformatf("t3 T2DONE c=%0d", c), T2DONE, (c >= 13) ? 1'b1 : 1'b0);
      if (c >= 1) chk($sformatf("t3 T1DONE c=%0d", c), T1DONE, 1'b0);
      next_cycle();
    end
    FREEZE = 1'b0;

    // 4: T1 expires at 12, one-cycle clear at 20, re-expires at 33;
    //    T2 cleared while done at cycle 0
    CLRT1 = 1'b0;
    CLRT2 = 1'b1;
    for (int c = 0; c < 41; c++) begin
      CLRT1 = (c == 20) ? 1'b1 : 1'b0;
      chk($sformatf("t4 T1DONE c=%0d", c), T1DONE,
          ((c >= 12 && c <= 20) || c >= 33) ? 1'b1 : 1'b0);
      chk($sformatf("t4 T2DONE c=%0d", c), T2DONE, (c == 0) ? 1'b1 : 1'b0);
      next_cycle();
    end

    // 5: restart both, CLR pulse at cycle 6 restarts both intervals
    CLRT1 = 1'b1;
    CLRT2 = 1'b1;
    next_cycle();
    CLRT1 = 1'b0;
    CLRT2 = 1'b0;
    for (int c = 0; c < 25; c++) begin
      CLR = (c == 6) ? 1'b1 : 1'b0;
      chk($sformatf("t5 T1DONE c=%0d", c), T1DONE, (c >= 19) ? 1'b1 : 1'b0);
      chk($sformatf("t5 T2DONE c=%0d", c), T2DONE, (c >= 15) ? 1'b1 : 1'b0);
      next_cycle();
    end
    CLR = 1'b0;

    // 6: staggered releases (T1 at 4, T2 at 8) expire on the same edge
    for (int c = 0; c < 22; c++) begin
      CLRT1 = (c < 4) ? 1'b1 : 1'b0;
      CLRT2 = (c < 8) ? 1'b1 : 1'b0;
      if (c >= 1) begin
        chk($sformatf("t6 T1DONE c=%0d", c), T1DONE, (c >= 16) ? 1'b1 : 1'b0);
        chk($sformatf("t6 T2DONE c=%0d", c), T2DONE, (c >= 16) ? 1'b1 : 1'b0);
      end
      next_cycle();
    end

    // 7: CLR overrides FREEZE and active counting on both timers
    FREEZE = 1'b1;
    CLR    = 1'b1;
    next_cycle();
    chk("t7 CLR T1DONE", T1DONE, 1'b0);
    chk("t7 CLR T2DONE", T2DONE, 1'b0);
    CLR    = 1'b0;
    FREEZE = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
